// File: rtl/ser_arbiter.sv
// Round-robin scheduler sharing one serializer between REQ_NUM requesters.
// Optional statistics (per-requester grant counts, timeout count) under SER_ARB_STAT_EN.
module ser_arbiter #(
  parameter int REQ_NUM  = 4,
  parameter int DATA_W   = 16,
  parameter int MOD_W    = 4,
  parameter int MIN_MOD  = 3,
  parameter int BUSY_TMO = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [REQ_NUM*DATA_W-1:0]  req_data_i,
  input  logic [REQ_NUM*MOD_W-1:0]   req_mod_i,
  input  logic [REQ_NUM-1:0]         req_val_i,
  output logic [REQ_NUM-1:0]         req_ready_o,
  output logic [DATA_W-1:0]          ser_data_o,
  output logic [MOD_W-1:0]           ser_mod_o,
  output logic                       ser_val_o,
  input  logic                       ser_busy_i,
  output logic                       drop_o,
  output logic                       err_o
`ifdef SER_ARB_STAT_EN
  ,
  input  logic [$clog2(REQ_NUM)-1:0] stat_sel_i,
  output logic [15:0]                stat_cnt_o,
  output logic [7:0]                 stat_err_cnt_o
`endif
);
  localparam int PTR_W = $clog2(REQ_NUM);
  localparam int CNT_W = $clog2(BUSY_TMO + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [MOD_W-1:0]  mod;
  } req_t;

  req_t [REQ_NUM-1:0] req;
  for (genvar g = 0; g < REQ_NUM; g++) begin : g_req
    assign req[g] = '{data: req_data_i[g*DATA_W +: DATA_W], mod: req_mod_i[g*MOD_W +: MOD_W]};
  end

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REQ_NUM-1:0] ready_q, ready_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [MOD_W-1:0]   mod_q, mod_d;
  logic               val_q, val_d;
  logic               drop_q, drop_d;
  logic               err_q, err_d;

  // Search upward from ptr+1 so the last winner has lowest priority.
  logic             win_vld;
  logic [PTR_W-1:0] win_idx;
  req_t             win_req;
  int               idx;
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      if (!win_vld && req_val_i[idx]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end
  assign win_req = req[win_idx];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ready_d = '0;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    drop_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          ready_d[win_idx] = 1'b1;
          ptr_d            = win_idx;
          if (win_req.mod >= MOD_W'(MIN_MOD)) begin
            data_d  = win_req.data;
            mod_d   = win_req.mod;
            val_d   = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_BUSY;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      WAIT_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // busy wins over a timeout landing on the same cycle
        if (ser_busy_i) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TMO - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!ser_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ready_q <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = ready_q;
  assign ser_data_o  = data_q;
  assign ser_mod_o   = mod_q;
  assign ser_val_o   = val_q;
  assign drop_o      = drop_q;
  assign err_o       = err_q;

`ifdef SER_ARB_STAT_EN
  logic [REQ_NUM-1:0][15:0] stat_q;
  logic [7:0]               stat_err_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_q     <= '0;
      stat_err_q <= '0;
    end else begin
      if (val_d) stat_q[win_idx] <= stat_q[win_idx] + 16'd1;
      if (err_d && stat_err_q != 8'hFF) stat_err_q <= stat_err_q + 8'd1;
    end
  end
  assign stat_cnt_o     = (int'(stat_sel_i) < REQ_NUM) ? stat_q[stat_sel_i] : 16'd0;
  assign stat_err_cnt_o = stat_err_q;
`endif
endmodule

// File: tb/tb_ser_arbiter.sv
// Randomized + directed bench for ser_arbiter against a cycle-level behavioural model.
// Build with SER_ARB_STAT_EN defined to also cover the statistics ports.
module tb_ser_arbiter;
  localparam int NREQ = 4, DW = 16, MW = 4, MINM = 3, TMO = 8;

  logic                gclk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ*DW-1:0]  req_data = '0;
  logic [NREQ*MW-1:0]  req_mod = '0;
  logic [NREQ-1:0]     req_val = '0;
  logic                busy = 1'b0;
  logic [NREQ-1:0]     ready;
  logic [DW-1:0]       ser_data;
  logic [MW-1:0]       ser_mod;
  logic                ser_val, drop, err;
`ifdef SER_ARB_STAT_EN
  logic [1:0]          stat_sel = '0;
  logic [15:0]         stat_cnt;
  logic [7:0]          stat_err;
`endif

  ser_arbiter #(.REQ_NUM(NREQ), .DATA_W(DW), .MOD_W(MW), .MIN_MOD(MINM), .BUSY_TMO(TMO)) dut (
    .clk_i(gclk), .rst_n_i(rst_n), .req_data_i(req_data), .req_mod_i(req_mod),
    .req_val_i(req_val), .req_ready_o(ready), .ser_data_o(ser_data), .ser_mod_o(ser_mod),
    .ser_val_o(ser_val), .ser_busy_i(busy), .drop_o(drop), .err_o(err)
`ifdef SER_ARB_STAT_EN
    , .stat_sel_i(stat_sel), .stat_cnt_o(stat_cnt), .stat_err_cnt_o(stat_err)
`endif
  );

  always #5 gclk = ~gclk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---- behavioural model: phases "issued, awaiting busy" and "serializer running"
  int           m_ptr, m_age;
  bit           m_wait, m_run;
  logic [3:0]   e_ready;
  logic         e_val, e_drop, e_err;
  logic [15:0]  e_data;
  logic [3:0]   e_mod;
  logic [15:0]  m_stat [NREQ];
  int           m_errs;

  task automatic model_reset();
    m_ptr = 0; m_age = 0; m_wait = 0; m_run = 0; m_errs = 0;
    e_ready = '0; e_val = 0; e_drop = 0; e_err = 0; e_data = '0; e_mod = '0;
    for (int k = 0; k < NREQ; k++) m_stat[k] = '0;
  endtask

  task automatic model_step();
    int w;
    e_ready = '0; e_val = 0; e_drop = 0; e_err = 0;
    if (m_run) begin
      if (!busy) m_run = 0;
    end else if (m_wait) begin
      m_age++;
      if (busy) begin
        m_wait = 0; m_run = 1;
      end else if (m_age >= TMO) begin
        m_wait = 0; e_err = 1;
        if (m_errs < 255) m_errs++;
      end
    end else begin
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && req_val[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      if (w >= 0) begin
        e_ready[w] = 1'b1;
        m_ptr = w;
        if (int'(req_mod[w*MW +: MW]) >= MINM) begin
          e_val = 1; e_data = req_data[w*DW +: DW]; e_mod = req_mod[w*MW +: MW];
          m_wait = 1; m_age = 0; m_stat[w]++;
        end else e_drop = 1;
      end
    end
  endtask

  // ---- stimulus drivers (requesters and a serializer stand-in)
  int  rq_mode = 0;      // 0: drop valid on ready, 1: keep valid, 2: random
  bit  sv_rand = 0;
  int  sv_fix_dly = 2, sv_fix_len = 2, sv_dly = 0, sv_len = 0;
  int  cyc = 0, fall_cyc = 0;
  int  glog[$];

  task automatic set_req(input int k, input logic [15:0] d, input logic [3:0] m);
    req_data[k*DW +: DW] = d;
    req_mod[k*MW +: MW]  = m;
    req_val[k]           = 1'b1;
  endtask

  task automatic drive();
    logic pb;
    for (int k = 0; k < NREQ; k++) begin
      if (ready[k]) begin
        if (rq_mode == 0) req_val[k] = 1'b0;
        else if (rq_mode == 1) req_data[k*DW +: DW] = 16'($urandom);
        else begin
          req_val[k] = 1'($urandom_range(0, 1));
          req_data[k*DW +: DW] = 16'($urandom);
          req_mod[k*MW +: MW] = 4'($urandom_range(0, 15));
        end
      end else if (rq_mode == 2) begin
        if (!req_val[k] && $urandom_range(0, 3) == 0) begin
          set_req(k, 16'($urandom), 4'($urandom_range(0, 15)));
        end else if (req_val[k] && $urandom_range(0, 31) == 0) req_val[k] = 1'b0;
      end
    end
    pb = busy;
    if (ser_val) begin
      if (sv_rand) begin
        sv_dly = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(0, 3);
        sv_len = $urandom_range(1, 6);
      end else begin
        sv_dly = sv_fix_dly; sv_len = sv_fix_len;
      end
      busy = 1'b0;
    end else if (sv_dly > 0) begin
      sv_dly--; busy = 1'b0;
    end else if (sv_len > 0) begin
      sv_len--; busy = 1'b1;
    end else busy = 1'b0;
    if (pb && !busy) fall_cyc = cyc;
`ifdef SER_ARB_STAT_EN
    if (rq_mode == 2) stat_sel = 2'($urandom_range(0, 3));
`endif
  endtask

  task automatic cmp_all();
    chk("ready", 32'(ready), 32'(e_ready));
    chk("ser_val", 32'(ser_val), 32'(e_val));
    chk("drop", 32'(drop), 32'(e_drop));
    chk("err", 32'(err), 32'(e_err));
    chk("ser_data", 32'(ser_data), 32'(e_data));
    chk("ser_mod", 32'(ser_mod), 32'(e_mod));
`ifdef SER_ARB_STAT_EN
    chk("stat_cnt", 32'(stat_cnt), 32'(m_stat[stat_sel]));
    chk("stat_err", 32'(stat_err), 32'(m_errs));
`endif
  endtask

  task automatic step();
    @(posedge gclk);
    cyc++;
    model_step();
    @(negedge gclk);
    cmp_all();
    for (int k = 0; k < NREQ; k++) if (ready[k]) glog.push_back(k);
    drive();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_val"}, 32'(ser_val), 0);
    chk({tag, "_drop"}, 32'(drop), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_data"}, 32'(ser_data), 0);
    chk({tag, "_mod"}, 32'(ser_mod), 0);
  endtask

  task automatic do_reset();
    @(negedge gclk);
    rst_n = 1'b0; busy = 1'b0; req_val = '0; sv_dly = 0; sv_len = 0;
    #1 chk_zero("rst");
    model_reset();
    @(negedge gclk);
    rst_n = 1'b1;
  endtask

  task automatic wait_val(input string tag, input int bound);
    int n = 0;
    do begin step(); n++; end while (!ser_val && n < bound);
    chk({tag, "_seen"}, 32'(ser_val), 1);
  endtask

  int exp_ord[5] = '{1, 2, 3, 0, 1};
  int n, n_err;

  initial begin
    model_reset();
    do_reset();

    // single requester, then next grant only after busy falls
    sv_fix_dly = 2; sv_fix_len = 16;
    set_req(2, 16'hA5C3, 4'd15);
    step();
    chk("t1_ready", 32'(ready), 32'b0100);
    chk("t1_val", 32'(ser_val), 1);
    chk("t1_data", 32'(ser_data), 32'hA5C3);
    chk("t1_mod", 32'(ser_mod), 15);
    set_req(2, 16'h5A3C, 4'd9);
    wait_val("t1_next", 60);
    chk("t1_gap", 32'(cyc - fall_cyc >= 2), 1);
    chk("t1_data2", 32'(ser_data), 32'h5A3C);

    // all requesters hold valid: grant order 1,2,3,0,1
    do_reset();
    rq_mode = 1; sv_fix_dly = 1; sv_fix_len = 2; glog.delete();
    for (int k = 0; k < NREQ; k++) set_req(k, 16'($urandom), 4'd8);
    n = 0;
    while (glog.size() < 5 && n < 200) begin step(); n++; end
    chk("t2_count", 32'(glog.size() >= 5), 1);
    for (int i = 0; i < 5; i++) chk("t2_order", 32'((i < glog.size()) ? glog[i] : -1), 32'(exp_ord[i]));
    rq_mode = 0;

    // low-mode request dropped, next cycle the next requester issued
    do_reset();
    set_req(3, 16'h3333, 4'd1);
    step();
    chk("t3_predrop", 32'(drop), 1);
    set_req(0, 16'h0BAD, 4'd2);
    set_req(1, 16'h1111, 4'd5);
    step();
    chk("t3_ready0", 32'(ready), 32'b0001);
    chk("t3_drop", 32'(drop), 1);
    chk("t3_noval", 32'(ser_val), 0);
    step();
    chk("t3_ready1", 32'(ready), 32'b0010);
    chk("t3_val", 32'(ser_val), 1);
    chk("t3_mod", 32'(ser_mod), 5);

    // busy never rises: timeout, then pending request granted
    do_reset();
    sv_fix_dly = 100; sv_fix_len = 1;
    set_req(1, 16'hC0DE, 4'd7);
    set_req(2, 16'h2222, 4'd4);
    step();
    chk("t4_ready1", 32'(ready), 32'b0010);
    n = 0;
    do begin step(); n++; end while (!err && n < 20);
    chk("t4_err_lat", 32'(n), 32'(TMO));
    step();
    chk("t4_ready2", 32'(ready), 32'b0100);
    chk("t4_val2", 32'(ser_val), 1);

    // busy rises exactly on the last timeout cycle: no error
    do_reset();
    sv_fix_dly = TMO - 2; sv_fix_len = 3;
    set_req(1, 16'h7777, 4'd7);
    step();
    n_err = 0;
    repeat (14) begin step(); if (err) n_err++; end
    chk("t4b_no_err", 32'(n_err), 0);

`ifdef SER_ARB_STAT_EN
    // statistics: three frames from requester 3, one timeout
    do_reset();
    sv_fix_dly = 1; sv_fix_len = 2;
    for (int i = 0; i < 3; i++) begin
      set_req(3, 16'(i + 16'h300), 4'd9);
      wait_val("ts_frame", 20);
      repeat (6) step();
    end
    sv_fix_dly = 100;
    set_req(0, 16'h0F0F, 4'd9);
    repeat (12) step();
    stat_sel = 2'd3;
    #1;
    chk("ts_cnt3", 32'(stat_cnt), 3);
    chk("ts_errcnt", 32'(stat_err), 1);
`endif

    // reset in the middle of a serializer transfer
    do_reset();
    sv_fix_dly = 0; sv_fix_len = 10;
    set_req(1, 16'h1234, 4'd6);
    step();
    chk("t5_data_pre", 32'(ser_data), 32'h1234);
    n = 0;
    do begin step(); n++; end while (!m_run && n < 10);
    chk("t5_in_xfer", 32'(m_run), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("t5_async");
    busy = 1'b0; sv_dly = 0; sv_len = 0; req_val = '0;
    model_reset();
    @(negedge gclk);
    rst_n = 1'b1;
    for (int k = 0; k < NREQ; k++) set_req(k, 16'(k + 16'h50), 4'd8);
    step();
    chk("t5_first", 32'(ready), 32'b0010);

    // random traffic against the model
    do_reset();
    rq_mode = 2; sv_rand = 1;
    repeat (4000) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
